// File: rtl/sub_serial_nbits.sv
// rtl/sub_serial_nbits.sv - digit-serial subtractor d = a - b - bi with valid/ready handshakes
module sub_serial_nbits #(
    parameter int BITS  = 32,
    parameter int DIGIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            bi,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] d,
    output logic            bo,
    output logic            ov
);

    localparam int N  = BITS / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [BITS-1:0] a_r;
    logic [BITS-1:0] b_r;
    logic [BITS-1:0] a_nxt;
    logic [BITS-1:0] b_nxt;
    logic [BITS-1:0] d_nxt;
    logic            a_msb;
    logic            b_msb;
    logic            c;
    logic [KW-1:0]   k;
    logic            last;
    logic [DIGIT:0]  dsum;

    assign last = (k == KW'(N - 1));

    // One digit of a + ~b + c; the low digit of the operand registers is always the current one.
    always_comb begin
        dsum = {1'b0, a_r[DIGIT-1:0]} + {1'b0, ~b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, c};
    end

    // Operands shift down one digit per RUN cycle; results enter d from the top so that
    // after N digits the whole difference sits in place.
    generate
        if (N > 1) begin : g_multi
            assign a_nxt = a_r >> DIGIT;
            assign b_nxt = b_r >> DIGIT;
            assign d_nxt = {dsum[DIGIT-1:0], d[BITS-1:DIGIT]};
        end else begin : g_single
            assign a_nxt = a_r;
            assign b_nxt = b_r;
            assign d_nxt = dsum[DIGIT-1:0];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after last digit, DONE -> IDLE on handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; in_ready is suppressed while reset is held.
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
    end

    // Datapath: latch operands at accept, process one digit per RUN cycle, set flags on the last digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            c     <= 1'b0;
            k     <= '0;
            d     <= '0;
            bo    <= 1'b0;
            ov    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        a_msb <= a[BITS-1];
                        b_msb <= b[BITS-1];
                        c     <= ~bi;
                        k     <= '0;
                    end
                end
                RUN: begin
                    a_r <= a_nxt;
                    b_r <= b_nxt;
                    d   <= d_nxt;
                    c   <= dsum[DIGIT];
                    k   <= k + 1'b1;
                    if (last) begin
                        bo <= ~dsum[DIGIT];
                        ov <= (a_msb != b_msb) && (dsum[DIGIT-1] != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial_nbits.sv
// tb/tb_sub_serial_nbits.sv - self-checking bench for sub_serial_nbits at DIGIT 8, 32 and 1
module tb_sub_serial_nbits;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        bi;
    logic [2:0]  in_valid_v;
    logic [2:0]  out_ready_v;

    logic        ir0, ir1, ir2;
    logic        ovl0, ovl1, ovl2;
    logic        bo0, bo1, bo2;
    logic        of0, of1, of2;
    logic [31:0] d0, d1, d2;

    logic [2:0]  in_ready_v;
    logic [2:0]  out_valid_v;
    logic [2:0]  bo_v;
    logic [2:0]  ov_v;

    assign in_ready_v  = {ir2, ir1, ir0};
    assign out_valid_v = {ovl2, ovl1, ovl0};
    assign bo_v        = {bo2, bo1, bo0};
    assign ov_v        = {of2, of1, of0};

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int nd [3] = '{4, 1, 32};

    always @(posedge clk) cyc <= cyc + 1;

    sub_serial_nbits #(.BITS(32), .DIGIT(8)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(ir0),
        .a(a), .b(b), .bi(bi), .out_valid(ovl0), .out_ready(out_ready_v[0]),
        .d(d0), .bo(bo0), .ov(of0)
    );

    sub_serial_nbits #(.BITS(32), .DIGIT(32)) u_d32 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(ir1),
        .a(a), .b(b), .bi(bi), .out_valid(ovl1), .out_ready(out_ready_v[1]),
        .d(d1), .bo(bo1), .ov(of1)
    );

    sub_serial_nbits #(.BITS(32), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(ir2),
        .a(a), .b(b), .bi(bi), .out_valid(ovl2), .out_ready(out_ready_v[2]),
        .d(d2), .bo(bo2), .ov(of2)
    );

    function automatic logic [31:0] get_d(input int u);
        case (u)
            0:       return d0;
            1:       return d1;
            default: return d2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the operands as integers.
    task automatic model(input logic [31:0] av, input logic [31:0] bv, input logic biv,
                         output logic [31:0] dx, output logic box, output logic ovx);
        longint ua, ub, sa, sb, sd;
        ua  = longint'({32'd0, av});
        ub  = longint'({32'd0, bv});
        sa  = longint'($signed(av));
        sb  = longint'($signed(bv));
        sd  = sa - sb - longint'(biv);
        dx  = 32'(ua - ub - longint'(biv));
        box = (ua < ub + longint'(biv));
        ovx = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    endtask

    // One full operation on unit u; returns the cycle of acceptance.
    task automatic run_op(input int u, input logic [31:0] av, input logic [31:0] bv,
                          input logic biv, input int hold, output int acc);
        int          n;
        int          lat;
        logic [31:0] dx;
        logic        box, ovx;
        a = av; b = bv; bi = biv;
        in_valid_v[u] = 1'b1;
        #1;
        n = 0;
        while (!in_ready_v[u] && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk($sformatf("u%0d accept_ready", u), 32'(in_ready_v[u]), 32'd1);
        acc = cyc;
        @(negedge clk);
        in_valid_v[u] = 1'b0;
        a = $urandom; b = $urandom; bi = 1'($urandom);
        lat = 1;
        while (!out_valid_v[u] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        model(av, bv, biv, dx, box, ovx);
        chk($sformatf("u%0d latency", u), 32'(lat), 32'(nd[u] + 1));
        chk($sformatf("u%0d d", u), get_d(u), dx);
        chk($sformatf("u%0d bo", u), 32'(bo_v[u]), 32'(box));
        chk($sformatf("u%0d ov", u), 32'(ov_v[u]), 32'(ovx));
        for (int i = 0; i < hold; i++) begin
            in_valid_v[u] = 1'b1;
            a = $urandom;
            @(negedge clk);
            chk($sformatf("u%0d hold_valid", u), 32'(out_valid_v[u]), 32'd1);
            chk($sformatf("u%0d hold_d", u), get_d(u), dx);
            chk($sformatf("u%0d hold_ready", u), 32'(in_ready_v[u]), 32'd0);
        end
        in_valid_v[u] = 1'b0;
        out_ready_v[u] = 1'b1;
        @(negedge clk);
        out_ready_v[u] = 1'b0;
        chk($sformatf("u%0d post_valid", u), 32'(out_valid_v[u]), 32'd0);
        chk($sformatf("u%0d post_ready", u), 32'(in_ready_v[u]), 32'd1);
        chk($sformatf("u%0d post_d", u), get_d(u), dx);
    endtask

    initial begin
        int acc1, acc2, rc;
        rst = 1'b1;
        in_valid_v = '0;
        out_ready_v = '0;
        a = '0; b = '0; bi = 1'b0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("u%0d rst_in_ready", u), 32'(in_ready_v[u]), 32'd0);
            chk($sformatf("u%0d rst_out_valid", u), 32'(out_valid_v[u]), 32'd0);
            chk($sformatf("u%0d rst_d", u), get_d(u), 32'd0);
            chk($sformatf("u%0d rst_bo", u), 32'(bo_v[u]), 32'd0);
            chk($sformatf("u%0d rst_ov", u), 32'(ov_v[u]), 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready_v), 32'd7);
        @(negedge clk);

        for (int u = 0; u < 3; u++) begin
            run_op(u, 32'd5, 32'd3, 1'b0, 0, acc1);
            run_op(u, 32'd0, 32'd1, 1'b0, 0, acc1);
            run_op(u, 32'h8000_0000, 32'd1, 1'b0, 0, acc1);
            run_op(u, 32'h0000_0100, 32'd0, 1'b1, 0, acc1);
            run_op(u, 32'd0, 32'd0, 1'b1, 0, acc1);
            run_op(u, 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 10, acc1);
            run_op(u, 32'hDEAD_BEEF, 32'h1111_2222, 1'b1, 0, acc1);
            run_op(u, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 0, acc2);
            chk($sformatf("u%0d b2b_spacing", u), 32'(acc2 - acc1), 32'(nd[u] + 2));

            // Leave bo=1, ov=1 and a non-zero d, then abort the next operation mid-RUN.
            run_op(u, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, acc1);
            a = 32'hCAFE_F00D; b = 32'h0000_1234; bi = 1'b0;
            in_valid_v[u] = 1'b1;
            @(negedge clk);
            in_valid_v[u] = 1'b0;
            rc = (nd[u] > 1) ? 2 : 1;
            for (int i = 1; i < rc; i++) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk($sformatf("u%0d midrst_out_valid", u), 32'(out_valid_v[u]), 32'd0);
            chk($sformatf("u%0d midrst_d", u), get_d(u), 32'd0);
            chk($sformatf("u%0d midrst_bo", u), 32'(bo_v[u]), 32'd0);
            chk($sformatf("u%0d midrst_ov", u), 32'(ov_v[u]), 32'd0);
            chk($sformatf("u%0d midrst_in_ready", u), 32'(in_ready_v[u]), 32'd0);
            rst = 1'b0;
            #1;
            chk($sformatf("u%0d midrst_release", u), 32'(in_ready_v[u]), 32'd1);
            @(negedge clk);
            run_op(u, 32'd10, 32'd4, 1'b0, 0, acc1);

            for (int r = 0; r < 15; r++) begin
                run_op(u, $urandom, $urandom, 1'($urandom), $urandom_range(0, 3), acc1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
